// File: rtl/player_pkg.sv
// Shared types, keycode defaults and helpers for the per-player movement engine.
package player_pkg;

  typedef enum logic [1:0] {OFF = 2'd0, IDLE = 2'd1, HOP = 2'd2, DEAD = 2'd3} anim_state_t;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [7:0] P1_KEY_UP    = 8'h1A;
  localparam logic [7:0] P1_KEY_DOWN  = 8'h16;
  localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
  localparam logic [7:0] P1_KEY_RIGHT = 8'h07;

  localparam logic [7:0] P2_KEY_UP    = 8'h52;
  localparam logic [7:0] P2_KEY_DOWN  = 8'h51;
  localparam logic [7:0] P2_KEY_LEFT  = 8'h50;
  localparam logic [7:0] P2_KEY_RIGHT = 8'h4F;

  // One frame of motion toward tgt; snaps onto tgt when it is within one step.
  function automatic coord_t step_toward(input coord_t cur, input coord_t tgt, input coord_t step);
    coord_t res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) <= step) ? tgt : cur + step;
    end else if (cur > tgt) begin
      res = ((cur - tgt) <= step) ? tgt : cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/player_key_decode.sv
// Scans the keycode report slots and reduces them to at most one direction request.
module player_key_decode
  import player_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 6,
  parameter logic [7:0]  KEY_UP    = P1_KEY_UP,
  parameter logic [7:0]  KEY_DOWN  = P1_KEY_DOWN,
  parameter logic [7:0]  KEY_LEFT  = P1_KEY_LEFT,
  parameter logic [7:0]  KEY_RIGHT = P1_KEY_RIGHT
) (
  input  logic [8*NUM_KEYS-1:0] i_keycodes,
  output logic                  o_valid_c,
  output dir_t                  o_dir_c
);

  logic w_up;
  logic w_dn;
  logic w_lt;
  logic w_rt;

  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    w_lt = 1'b0;
    w_rt = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (i_keycodes[i*8 +: 8] == KEY_UP)    w_up = 1'b1;
      if (i_keycodes[i*8 +: 8] == KEY_DOWN)  w_dn = 1'b1;
      if (i_keycodes[i*8 +: 8] == KEY_LEFT)  w_lt = 1'b1;
      if (i_keycodes[i*8 +: 8] == KEY_RIGHT) w_rt = 1'b1;
    end
  end

  // Opposing keys cancel per axis, then fixed priority UP > DOWN > LEFT > RIGHT.
  always_comb begin
    o_valid_c = 1'b0;
    o_dir_c   = UP;
    if (w_up && !w_dn) begin
      o_valid_c = 1'b1;
      o_dir_c   = UP;
    end else if (w_dn && !w_up) begin
      o_valid_c = 1'b1;
      o_dir_c   = DOWN;
    end else if (w_lt && !w_rt) begin
      o_valid_c = 1'b1;
      o_dir_c   = LEFT;
    end else if (w_rt && !w_lt) begin
      o_valid_c = 1'b1;
      o_dir_c   = RIGHT;
    end
  end

endmodule

// File: rtl/player_hopper.sv
// Per-player grid-hop movement engine: key requests become animated hops, with death and respawn.
module player_hopper
  import player_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 6,
  parameter logic [7:0]  KEY_UP       = P1_KEY_UP,
  parameter logic [7:0]  KEY_DOWN     = P1_KEY_DOWN,
  parameter logic [7:0]  KEY_LEFT     = P1_KEY_LEFT,
  parameter logic [7:0]  KEY_RIGHT    = P1_KEY_RIGHT,
  parameter int unsigned SPAWN_X      = 220,
  parameter int unsigned SPAWN_Y      = 400,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 624,
  parameter int unsigned Y_MIN        = 32,
  parameter int unsigned Y_MAX        = 448,
  parameter int unsigned HOP_DIST     = 16,
  parameter int unsigned STEP         = 4,
  parameter int unsigned ANIM_DIV     = 4,
  parameter int unsigned ANIM_FRAMES  = 4,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic                  FrameClk,
  input  logic                  ResetN,
  input  logic                  SpawnEnable,
  input  logic                  Kill,
  input  logic [8*NUM_KEYS-1:0] Keycodes,
  output logic [9:0]            PlayerX,
  output logic [9:0]            PlayerY,
  output logic [1:0]            Facing,
  output logic [1:0]            AnimState,
  output logic [2:0]            AnimFrame,
  output logic                  Dead
);

  localparam int unsigned EXT_W = COORD_W + 1;
  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [EXT_W-1:0] EXT_HOP   = EXT_W'(HOP_DIST);
  localparam logic [EXT_W-1:0] EXT_X_MIN = EXT_W'(X_MIN);
  localparam logic [EXT_W-1:0] EXT_X_MAX = EXT_W'(X_MAX);
  localparam logic [EXT_W-1:0] EXT_Y_MIN = EXT_W'(Y_MIN);
  localparam logic [EXT_W-1:0] EXT_Y_MAX = EXT_W'(Y_MAX);
  localparam coord_t           C_SPAWN_X = COORD_W'(SPAWN_X);
  localparam coord_t           C_SPAWN_Y = COORD_W'(SPAWN_Y);
  localparam coord_t           C_STEP    = COORD_W'(STEP);

  anim_state_t      r_state,  w_nxt_state;
  coord_t           r_x,      w_nxt_x;
  coord_t           r_y,      w_nxt_y;
  coord_t           r_tx,     w_nxt_tx;
  coord_t           r_ty,     w_nxt_ty;
  dir_t             r_facing, w_nxt_facing;
  logic [2:0]       r_frame,  w_nxt_frame;
  logic [DIV_W-1:0] r_div,    w_nxt_div;
  logic [CNT_W-1:0] r_cnt,    w_nxt_cnt;
  logic             r_dead,   w_nxt_dead;

  logic             w_req_valid;
  dir_t             w_req_dir;
  logic [EXT_W-1:0] w_x_ext;
  logic [EXT_W-1:0] w_y_ext;
  logic [EXT_W-1:0] w_x_dec;
  logic [EXT_W-1:0] w_y_dec;
  logic [EXT_W-1:0] w_x_inc;
  logic [EXT_W-1:0] w_y_inc;
  coord_t           w_tgt_x;
  coord_t           w_tgt_y;
  coord_t           w_step_x;
  coord_t           w_step_y;

  player_key_decode #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_UP    (KEY_UP),
    .KEY_DOWN  (KEY_DOWN),
    .KEY_LEFT  (KEY_LEFT),
    .KEY_RIGHT (KEY_RIGHT)
  ) u_key_decode (
    .i_keycodes (Keycodes),
    .o_valid_c  (w_req_valid),
    .o_dir_c    (w_req_dir)
  );

  // Candidate hop targets kept 11 bits wide so a step below the low bound cannot wrap.
  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};
  assign w_x_dec = w_x_ext - EXT_HOP;
  assign w_y_dec = w_y_ext - EXT_HOP;
  assign w_x_inc = w_x_ext + EXT_HOP;
  assign w_y_inc = w_y_ext + EXT_HOP;

  always_comb begin
    w_tgt_x = r_x;
    w_tgt_y = r_y;
    case (w_req_dir)
      UP:      w_tgt_y = (w_y_ext < EXT_Y_MIN + EXT_HOP) ? COORD_W'(Y_MIN) : w_y_dec[COORD_W-1:0];
      DOWN:    w_tgt_y = (w_y_inc > EXT_Y_MAX)           ? COORD_W'(Y_MAX) : w_y_inc[COORD_W-1:0];
      LEFT:    w_tgt_x = (w_x_ext < EXT_X_MIN + EXT_HOP) ? COORD_W'(X_MIN) : w_x_dec[COORD_W-1:0];
      RIGHT:   w_tgt_x = (w_x_inc > EXT_X_MAX)           ? COORD_W'(X_MAX) : w_x_inc[COORD_W-1:0];
      default: ;
    endcase
  end

  assign w_step_x = step_toward(r_x, r_tx, C_STEP);
  assign w_step_y = step_toward(r_y, r_ty, C_STEP);

  // Next-state, position, facing, death counter and animation.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_x      = r_x;
    w_nxt_y      = r_y;
    w_nxt_tx     = r_tx;
    w_nxt_ty     = r_ty;
    w_nxt_facing = r_facing;
    w_nxt_frame  = r_frame;
    w_nxt_div    = r_div;
    w_nxt_cnt    = r_cnt;

    if (!SpawnEnable) begin
      w_nxt_state  = OFF;
      w_nxt_x      = C_SPAWN_X;
      w_nxt_y      = C_SPAWN_Y;
      w_nxt_facing = UP;
      w_nxt_cnt    = '0;
    end else begin
      case (r_state)
        OFF: w_nxt_state = IDLE;
        IDLE: begin
          if (Kill) begin
            w_nxt_state = DEAD;
            w_nxt_cnt   = '0;
          end else if (w_req_valid) begin
            w_nxt_facing = w_req_dir;
            if ((w_tgt_x != r_x) || (w_tgt_y != r_y)) begin
              w_nxt_tx    = w_tgt_x;
              w_nxt_ty    = w_tgt_y;
              w_nxt_state = HOP;
            end
          end
        end
        HOP: begin
          if (Kill) begin
            w_nxt_state = DEAD;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_x = w_step_x;
            w_nxt_y = w_step_y;
            if ((w_step_x == r_tx) && (w_step_y == r_ty)) w_nxt_state = IDLE;
          end
        end
        DEAD: begin
          if (r_cnt == CNT_W'(DEATH_FRAMES - 1)) begin
            w_nxt_state  = IDLE;
            w_nxt_x      = C_SPAWN_X;
            w_nxt_y      = C_SPAWN_Y;
            w_nxt_facing = UP;
            w_nxt_cnt    = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: w_nxt_state = OFF;
      endcase
    end

    if (w_nxt_state != r_state) begin
      w_nxt_frame = '0;
      w_nxt_div   = '0;
    end else if ((r_state == HOP) || (r_state == DEAD)) begin
      if (r_div == DIV_W'(ANIM_DIV - 1)) begin
        w_nxt_div   = '0;
        w_nxt_frame = (r_frame == 3'(ANIM_FRAMES - 1)) ? 3'd0 : r_frame + 3'd1;
      end else begin
        w_nxt_div = r_div + DIV_W'(1);
      end
    end else begin
      w_nxt_frame = '0;
      w_nxt_div   = '0;
    end

    w_nxt_dead = (w_nxt_state == DEAD);
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= OFF;
      r_x      <= C_SPAWN_X;
      r_y      <= C_SPAWN_Y;
      r_tx     <= C_SPAWN_X;
      r_ty     <= C_SPAWN_Y;
      r_facing <= UP;
      r_frame  <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_dead   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_x      <= w_nxt_x;
      r_y      <= w_nxt_y;
      r_tx     <= w_nxt_tx;
      r_ty     <= w_nxt_ty;
      r_facing <= w_nxt_facing;
      r_frame  <= w_nxt_frame;
      r_div    <= w_nxt_div;
      r_cnt    <= w_nxt_cnt;
      r_dead   <= w_nxt_dead;
    end
  end

  assign PlayerX   = r_x;
  assign PlayerY   = r_y;
  assign Facing    = 2'(r_facing);
  assign AnimState = 2'(r_state);
  assign AnimFrame = r_frame;
  assign Dead      = r_dead;

endmodule

// File: tb/tb_player_hopper.sv
// Scoreboard bench for player_hopper: a behavioural model queues expected outputs each frame.
module tb_player_hopper;

  localparam int NK = 6;
  localparam logic [7:0] K_UP = 8'h1A, K_DN = 8'h16, K_LT = 8'h04, K_RT = 8'h07;

  logic          FrameClk = 1'b0;
  logic          ResetN   = 1'b1;
  logic          SpawnEnable = 1'b0;
  logic          Kill = 1'b0;
  logic [8*NK-1:0] Keycodes = '0;
  logic [9:0]    PlayerX, PlayerY;
  logic [1:0]    Facing, AnimState;
  logic [2:0]    AnimFrame;
  logic          Dead;

  player_hopper dut (
    .FrameClk    (FrameClk),
    .ResetN      (ResetN),
    .SpawnEnable (SpawnEnable),
    .Kill        (Kill),
    .Keycodes    (Keycodes),
    .PlayerX     (PlayerX),
    .PlayerY     (PlayerY),
    .Facing      (Facing),
    .AnimState   (AnimState),
    .AnimFrame   (AnimFrame),
    .Dead        (Dead)
  );

  always #5 FrameClk = ~FrameClk;

  typedef struct {
    int x; int y; int face; int st; int frm; int dead;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state: st 0=OFF 1=IDLE 2=HOP 3=DEAD; face 0=UP 1=DOWN 2=LEFT 3=RIGHT
  int m_st, m_x, m_y, m_tx, m_ty, m_face, m_frm, m_div, m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [8*NK-1:0] key_in(input int slot, input logic [7:0] code);
    logic [8*NK-1:0] k;
    k = '0;
    k[slot*8 +: 8] = code;
    return k;
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = 220; m_y = 400; m_tx = 220; m_ty = 400;
    m_face = 0; m_frm = 0; m_div = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit sen, input bit kill, input logic [8*NK-1:0] keys);
    bit up, dn, lt, rt;
    int req, prev, dx, dy, tx, ty;
    logic [7:0] k;
    up = 0; dn = 0; lt = 0; rt = 0;
    for (int i = 0; i < NK; i++) begin
      k = keys[i*8 +: 8];
      if (k == K_UP) up = 1;
      if (k == K_DN) dn = 1;
      if (k == K_LT) lt = 1;
      if (k == K_RT) rt = 1;
    end
    if (up && dn) begin up = 0; dn = 0; end
    if (lt && rt) begin lt = 0; rt = 0; end
    req = up ? 0 : dn ? 1 : lt ? 2 : rt ? 3 : -1;
    prev = m_st;
    if (!sen) begin
      m_st = 0; m_x = 220; m_y = 400; m_face = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: begin
          if (kill) begin
            m_st = 3; m_cnt = 0;
          end else if (req >= 0) begin
            m_face = req;
            dx = (req == 2) ? -16 : (req == 3) ? 16 : 0;
            dy = (req == 0) ? -16 : (req == 1) ? 16 : 0;
            tx = clampi(m_x + dx, 0, 624);
            ty = clampi(m_y + dy, 32, 448);
            if (tx != m_x || ty != m_y) begin
              m_tx = tx; m_ty = ty; m_st = 2;
            end
          end
        end
        2: begin
          if (kill) begin
            m_st = 3; m_cnt = 0;
          end else begin
            if (m_x < m_tx) m_x = (m_x + 4 > m_tx) ? m_tx : m_x + 4;
            else if (m_x > m_tx) m_x = (m_x - 4 < m_tx) ? m_tx : m_x - 4;
            if (m_y < m_ty) m_y = (m_y + 4 > m_ty) ? m_ty : m_y + 4;
            else if (m_y > m_ty) m_y = (m_y - 4 < m_ty) ? m_ty : m_y - 4;
            if (m_x == m_tx && m_y == m_ty) m_st = 1;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == 60) begin
            m_st = 1; m_x = 220; m_y = 400; m_face = 0;
          end
        end
      endcase
    end
    if (m_st != prev) begin
      m_frm = 0; m_div = 0;
    end else if (m_st == 2 || m_st == 3) begin
      m_div++;
      if (m_div == 4) begin
        m_div = 0;
        m_frm = (m_frm + 1) % 4;
      end
    end else begin
      m_frm = 0; m_div = 0;
    end
    q_exp.push_back('{x: m_x, y: m_y, face: m_face, st: m_st, frm: m_frm, dead: (m_st == 3)});
  endtask

  task automatic score();
    exp_t e;
    if (q_exp.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty got no queued expectation (t=%0t)", $time);
      return;
    end
    e = q_exp.pop_front();
    check("sb_x",     int'(PlayerX),   e.x);
    check("sb_y",     int'(PlayerY),   e.y);
    check("sb_face",  int'(Facing),    e.face);
    check("sb_state", int'(AnimState), e.st);
    check("sb_frame", int'(AnimFrame), e.frm);
    check("sb_dead",  int'(Dead),      e.dead);
  endtask

  task automatic drive_frame(input bit sen, input bit kill, input logic [8*NK-1:0] keys);
    SpawnEnable = sen;
    Kill        = kill;
    Keycodes    = keys;
    model_step(sen, kill, keys);
    @(posedge FrameClk);
    #1;
    score();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},     int'(PlayerX),   220);
    check({tag, "_y"},     int'(PlayerY),   400);
    check({tag, "_face"},  int'(Facing),    0);
    check({tag, "_state"}, int'(AnimState), 0);
    check({tag, "_frame"}, int'(AnimFrame), 0);
    check({tag, "_dead"},  int'(Dead),      0);
  endtask

  initial begin
    logic [8*NK-1:0] k_up, k_lt, k_mix, k_rand;
    k_up  = key_in(3, K_UP);
    k_lt  = key_in(1, K_LT);
    k_mix = key_in(0, K_UP) | key_in(2, K_DN) | key_in(5, K_RT);
    model_reset();

    #2 ResetN = 1'b0;
    #1 check_reset_vals("rst");
    @(posedge FrameClk);
    @(posedge FrameClk);
    #1 ResetN = 1'b1;

    // spawn into IDLE
    drive_frame(1, 0, '0);
    check("spawn_state", int'(AnimState), 1);
    check("spawn_y", int'(PlayerY), 400);

    // single up press: one hop over four frames
    drive_frame(1, 0, k_up);
    check("hop_start_state", int'(AnimState), 2);
    for (int i = 0; i < 4; i++) begin
      drive_frame(1, 0, '0);
      check("hop_y", int'(PlayerY), 396 - 4 * i);
    end
    check("hop_land_state", int'(AnimState), 1);

    // held up: lands at 368, re-hops on the next frame
    for (int i = 0; i < 6; i++) drive_frame(1, 0, k_up);
    check("repeat_state", int'(AnimState), 2);
    check("repeat_y", int'(PlayerY), 368);
    for (int i = 0; i < 4; i++) drive_frame(1, 0, '0);
    check("repeat_land_y", int'(PlayerY), 352);

    // up+down cancel, right wins from another slot
    drive_frame(1, 0, k_mix);
    check("cancel_face", int'(Facing), 3);
    for (int i = 0; i < 4; i++) drive_frame(1, 0, '0);
    check("cancel_x", int'(PlayerX), 236);
    check("cancel_y", int'(PlayerY), 352);

    // hold left into the X_MIN clamp, then stay IDLE at the bound
    for (int i = 0; i < 90; i++) drive_frame(1, 0, k_lt);
    check("clamp_x", int'(PlayerX), 0);
    check("clamp_y", int'(PlayerY), 352);
    check("clamp_state", int'(AnimState), 1);
    check("clamp_face", int'(Facing), 2);

    // back to spawn, Kill ignored while OFF
    drive_frame(0, 0, '0);
    check("off_x", int'(PlayerX), 220);
    drive_frame(1, 1, '0);
    check("off_kill_state", int'(AnimState), 1);

    // kill mid-hop at 392, sixty DEAD frames, extra kills ignored
    drive_frame(1, 0, k_up);
    drive_frame(1, 0, '0);
    drive_frame(1, 0, '0);
    drive_frame(1, 1, '0);
    check("kill_dead", int'(Dead), 1);
    check("kill_y", int'(PlayerY), 392);
    for (int i = 1; i < 60; i++) begin
      drive_frame(1, (i == 20) || (i == 40), (i == 10) ? k_up : '0);
      check("dead_hold", int'(Dead), 1);
      check("dead_frozen_y", int'(PlayerY), 392);
    end
    drive_frame(1, 0, '0);
    check("respawn_state", int'(AnimState), 1);
    check("respawn_x", int'(PlayerX), 220);
    check("respawn_y", int'(PlayerY), 400);
    check("respawn_dead", int'(Dead), 0);

    // Kill beats a simultaneous key request
    drive_frame(1, 1, k_up);
    check("kill_wins_state", int'(AnimState), 3);
    check("kill_wins_y", int'(PlayerY), 400);
    for (int i = 0; i < 60; i++) drive_frame(1, 0, '0);
    check("kill_wins_respawn", int'(AnimState), 1);

    // SpawnEnable dropped mid-hop
    drive_frame(1, 0, k_up);
    drive_frame(1, 0, '0);
    drive_frame(1, 0, '0);
    drive_frame(0, 0, k_up);
    check("drop_state", int'(AnimState), 0);
    check("drop_y", int'(PlayerY), 400);
    drive_frame(1, 0, '0);

    // asynchronous reset mid-hop
    drive_frame(1, 0, key_in(0, K_DN));
    drive_frame(1, 0, '0);
    check("pre_rst_y", int'(PlayerY), 404);
    #2 ResetN = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    #2 ResetN = 1'b1;
    drive_frame(1, 0, '0);
    check("post_rst_state", int'(AnimState), 1);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      k_rand = '0;
      for (int s = 0; s < NK; s++) begin
        case ($urandom_range(0, 9))
          0: k_rand[s*8 +: 8] = K_UP;
          1: k_rand[s*8 +: 8] = K_DN;
          2: k_rand[s*8 +: 8] = K_LT;
          3: k_rand[s*8 +: 8] = K_RT;
          4: k_rand[s*8 +: 8] = 8'h33;
          default: k_rand[s*8 +: 8] = 8'h00;
        endcase
      end
      drive_frame(($urandom_range(0, 49) != 0), ($urandom_range(0, 39) == 0), k_rand);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
